// File: rtl/alarm_ctrl_pkg.sv
// Shared encodings, limits and BCD helpers for the alarm clock controller.
package alarm_ctrl_pkg;

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_SET_T_HR  = 3'd1;
    localparam logic [2:0] ST_SET_T_MIN = 3'd2;
    localparam logic [2:0] ST_SET_A_HR  = 3'd3;
    localparam logic [2:0] ST_SET_A_MIN = 3'd4;

    localparam int unsigned HOUR_MAX    = 23;
    localparam int unsigned MIN_SEC_MAX = 59;
    localparam int unsigned RING_TICKS  = 60;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
    } bcd_time_t;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input int unsigned max);
        if (v == to_bcd(max))
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter; carry flags the wrap on an enabled step.
module bcd_mod_cnt
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       carry
);

    logic [7:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 8'h00;
        else if (clr)
            q <= 8'h00;
        else if (en)
            q <= bcd_next(q, MAX);
    end

    assign {d1, d0} = q;
    // A clear wins over the step, so it must not ripple into the next field.
    assign carry = en && !clr && (q == to_bcd(MAX));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock: BCD time of day, settable alarm, ring timeout and stop.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       stop_btn,
    input  logic       alarm_en,
    output logic [2:0] mode,
    output logic [3:0] disp_h1,
    output logic [3:0] disp_h0,
    output logic [3:0] disp_m1,
    output logic [3:0] disp_m0,
    output logic [3:0] disp_s1,
    output logic [3:0] disp_s0,
    output logic       ringing
);

    logic [2:0] mode_q;
    logic       set_t, show_alarm, tick_adv, inc_ok, sec_clr;
    logic [7:0] t_sec, t_min, t_hr, a_min, a_hr;
    logic       sec_c, min_c, hr_c, a_min_c, a_hr_c;
    logic [7:0] nxt_min, nxt_hr;
    logic       trigger;
    logic       ringing_q;
    logic [5:0] ring_cnt;
    bcd_time_t  disp;
    logic       unused_carries;

    assign set_t      = (mode_q == ST_SET_T_HR) || (mode_q == ST_SET_T_MIN);
    assign show_alarm = (mode_q == ST_SET_A_HR) || (mode_q == ST_SET_A_MIN);
    assign tick_adv   = tick_1hz && !set_t;
    assign inc_ok     = inc_btn && !mode_btn;
    assign sec_clr    = mode_btn && (mode_q == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= ST_RUN;
        else if (mode_btn)
            mode_q <= (mode_q == ST_SET_A_MIN) ? ST_RUN : mode_q + 3'd1;
    end

    bcd_mod_cnt #(.MAX(MIN_SEC_MAX)) u_t_sec (
        .clk(clk), .rst_n(rst_n), .en(tick_adv), .clr(sec_clr),
        .d1(t_sec[7:4]), .d0(t_sec[3:0]), .carry(sec_c)
    );

    bcd_mod_cnt #(.MAX(MIN_SEC_MAX)) u_t_min (
        .clk(clk), .rst_n(rst_n),
        .en((tick_adv && sec_c) || (inc_ok && mode_q == ST_SET_T_MIN)), .clr(1'b0),
        .d1(t_min[7:4]), .d0(t_min[3:0]), .carry(min_c)
    );

    // Minute carry only counts when the step came from the seconds chain.
    bcd_mod_cnt #(.MAX(HOUR_MAX)) u_t_hr (
        .clk(clk), .rst_n(rst_n),
        .en((tick_adv && min_c) || (inc_ok && mode_q == ST_SET_T_HR)), .clr(1'b0),
        .d1(t_hr[7:4]), .d0(t_hr[3:0]), .carry(hr_c)
    );

    bcd_mod_cnt #(.MAX(MIN_SEC_MAX)) u_a_min (
        .clk(clk), .rst_n(rst_n), .en(inc_ok && mode_q == ST_SET_A_MIN), .clr(1'b0),
        .d1(a_min[7:4]), .d0(a_min[3:0]), .carry(a_min_c)
    );

    bcd_mod_cnt #(.MAX(HOUR_MAX)) u_a_hr (
        .clk(clk), .rst_n(rst_n), .en(inc_ok && mode_q == ST_SET_A_HR), .clr(1'b0),
        .d1(a_hr[7:4]), .d0(a_hr[3:0]), .carry(a_hr_c)
    );

    assign unused_carries = &{1'b0, hr_c, a_min_c, a_hr_c};

    // Trigger fires on the tick that rolls the time onto alarm hh:mm:00.
    assign nxt_min = bcd_next(t_min, MIN_SEC_MAX);
    assign nxt_hr  = (t_min == to_bcd(MIN_SEC_MAX)) ? bcd_next(t_hr, HOUR_MAX) : t_hr;
    assign trigger = alarm_en && tick_adv && !sec_clr && (t_sec == to_bcd(MIN_SEC_MAX)) &&
                     (nxt_min == a_min) && (nxt_hr == a_hr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ringing_q <= 1'b0;
            ring_cnt  <= 6'd0;
        end else if (!alarm_en) begin
            ringing_q <= 1'b0;
            ring_cnt  <= 6'd0;
        end else if (trigger) begin
            ringing_q <= 1'b1;
            ring_cnt  <= ringing_q ? ring_cnt + 6'd1 : 6'd0;
        end else if (ringing_q) begin
            if (stop_btn) begin
                ringing_q <= 1'b0;
                ring_cnt  <= 6'd0;
            end else if (tick_1hz) begin
                if (ring_cnt >= 6'(RING_TICKS - 1)) begin
                    ringing_q <= 1'b0;
                    ring_cnt  <= 6'd0;
                end else begin
                    ring_cnt <= ring_cnt + 6'd1;
                end
            end
        end
    end

    always_comb begin
        disp = '{hr: t_hr, min: t_min, sec: t_sec};
        if (show_alarm)
            disp = '{hr: a_hr, min: a_min, sec: 8'h00};
    end

    assign mode    = mode_q;
    assign ringing = ringing_q;
    assign {disp_h1, disp_h0} = disp.hr;
    assign {disp_m1, disp_m0} = disp.min;
    assign {disp_s1, disp_s0} = disp.sec;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random buttons vs a seconds-count model.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0, stop_btn = 1'b0;
    logic       alarm_en = 1'b0;
    logic [2:0] mode;
    logic [3:0] disp_h1, disp_h0, disp_m1, disp_m0, disp_s1, disp_s0;
    logic       ringing;
    logic [23:0] disp_all;

    int total = 0;
    int bad = 0;

    // Model: time as seconds since midnight, alarm as hour/minute integers.
    int m_time, a_h, a_m, m_mode, m_el;
    bit m_ring;

    alarm_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .stop_btn(stop_btn), .alarm_en(alarm_en), .mode(mode),
        .disp_h1(disp_h1), .disp_h0(disp_h0), .disp_m1(disp_m1), .disp_m0(disp_m0),
        .disp_s1(disp_s1), .disp_s0(disp_s0), .ringing(ringing)
    );

    assign disp_all = {disp_h1, disp_h0, disp_m1, disp_m0, disp_s1, disp_s0};

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_time = 0; a_h = 0; a_m = 0; m_mode = 0; m_ring = 0; m_el = 0;
    endfunction

    function automatic void model_step(bit tk, bit md, bit inc, bit stp);
        bit adv, trig;
        int h, mi, s;
        adv  = tk && m_mode != 1 && m_mode != 2;
        trig = 0;
        if (md && m_mode == 0)
            m_time = m_time - m_time % 60;
        else if (adv) begin
            m_time = (m_time + 1) % 86400;
            trig = alarm_en && (m_time == a_h * 3600 + a_m * 60);
        end
        if (inc && !md) begin
            h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
            case (m_mode)
                1: m_time = ((h + 1) % 24) * 3600 + mi * 60 + s;
                2: m_time = h * 3600 + ((mi + 1) % 60) * 60 + s;
                3: a_h = (a_h + 1) % 24;
                4: a_m = (a_m + 1) % 60;
                default: ;
            endcase
        end
        if (!alarm_en) begin
            m_ring = 0; m_el = 0;
        end else if (trig) begin
            if (!m_ring) begin m_ring = 1; m_el = 0; end
            else m_el++;
        end else if (m_ring) begin
            if (stp) begin
                m_ring = 0; m_el = 0;
            end else if (tk) begin
                m_el++;
                if (m_el >= 60) begin m_ring = 0; m_el = 0; end
            end
        end
        if (md) m_mode = (m_mode + 1) % 5;
    endfunction

    function automatic logic [23:0] exp_disp();
        int h, mi, s;
        if (m_mode == 3 || m_mode == 4) begin
            h = a_h; mi = a_m; s = 0;
        end else begin
            h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
        end
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic step(input bit tk, input bit md, input bit inc, input bit stp);
        tick_1hz = tk; mode_btn = md; inc_btn = inc; stop_btn = stp;
        @(posedge clk);
        model_step(tk, md, inc, stp);
        #1;
        tick_1hz = 0; mode_btn = 0; inc_btn = 0; stop_btn = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0);
    endtask

    task automatic modes(input int n);
        repeat (n) step(0, 1, 0, 0);
    endtask

    task automatic incs(input int n);
        repeat (n) step(0, 0, 1, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; alarm_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
        total++; if (disp_all !== 24'h000000) begin bad++; $display("FAIL reset_disp: got %h want 000000", disp_all); end
        total++; if (ringing !== 1'b0) begin bad++; $display("FAIL reset_ring: got %b want 0", ringing); end
    endtask

    task automatic test_set_time();
        ticks(37);
        total++; if (disp_all !== 24'h000037) begin bad++; $display("FAIL run_37s: got %h want 000037", disp_all); end
        modes(1);
        total++; if (disp_all !== 24'h000000 || mode !== 3'd1) begin bad++; $display("FAIL enter_set_clears_sec: got %h/%0d want 000000/1", disp_all, mode); end
        incs(25);
        ticks(3);
        total++; if (disp_all !== 24'h010000) begin bad++; $display("FAIL hour_inc_25: got %h want 010000", disp_all); end
        modes(1);
        incs(61);
        ticks(2);
        total++; if (disp_all !== 24'h010100 || mode !== 3'd2) begin bad++; $display("FAIL min_inc_61: got %h/%0d want 010100/2", disp_all, mode); end
        total++; if (disp_all !== exp_disp()) begin bad++; $display("FAIL set_time_model: got %h want %h", disp_all, exp_disp()); end
    endtask

    task automatic test_wrap();
        modes(4);
        incs(22);
        modes(1);
        incs(58);
        modes(3);
        total++; if (disp_all !== 24'h235900 || mode !== 3'd0) begin bad++; $display("FAIL preload_2359: got %h/%0d want 235900/0", disp_all, mode); end
        ticks(58);
        total++; if (disp_all !== 24'h235958) begin bad++; $display("FAIL wrap_pre: got %h want 235958", disp_all); end
        ticks(1);
        total++; if (disp_all !== 24'h235959) begin bad++; $display("FAIL wrap_59: got %h want 235959", disp_all); end
        ticks(1);
        total++; if (disp_all !== 24'h000000) begin bad++; $display("FAIL wrap_midnight: got %h want 000000", disp_all); end
    endtask

    task automatic test_alarm_timeout();
        modes(1); incs(7);
        modes(1); incs(29);
        modes(1); incs(7);
        modes(1); incs(30);
        total++; if (disp_all !== 24'h073000 || mode !== 3'd4) begin bad++; $display("FAIL alarm_disp: got %h/%0d want 073000/4", disp_all, mode); end
        modes(1);
        alarm_en = 1;
        ticks(59);
        total++; if (disp_all !== 24'h072959 || ringing !== 1'b0) begin bad++; $display("FAIL pre_trigger: got %h/%b want 072959/0", disp_all, ringing); end
        ticks(1);
        total++; if (ringing !== 1'b1) begin bad++; $display("FAIL trigger: got %b want 1", ringing); end
        ticks(59);
        total++; if (ringing !== 1'b1) begin bad++; $display("FAIL ring_59: got %b want 1", ringing); end
        ticks(1);
        total++; if (ringing !== 1'b0 || disp_all !== 24'h073100) begin bad++; $display("FAIL ring_timeout: got %b/%h want 0/073100", ringing, disp_all); end
    endtask

    task automatic test_stop_collision();
        modes(2); incs(58);
        modes(3);
        ticks(60);
        ticks(10);
        total++; if (disp_all !== 24'h073010 || ringing !== 1'b1) begin bad++; $display("FAIL ring_at_10s: got %h/%b want 073010/1", disp_all, ringing); end
        step(0, 0, 0, 1);
        total++; if (ringing !== 1'b0) begin bad++; $display("FAIL stop_clears: got %b want 0", ringing); end
        step(0, 0, 0, 1);
        total++; if (ringing !== 1'b0) begin bad++; $display("FAIL stop_idle: got %b want 0", ringing); end
        step(0, 1, 1, 0);
        total++; if (mode !== 3'd1 || disp_all !== 24'h073000) begin bad++; $display("FAIL mode_inc_collide: got %0d/%h want 1/073000", mode, disp_all); end
        modes(1);
        step(0, 1, 1, 0);
        total++; if (mode !== 3'd3 || disp_all !== exp_disp()) begin bad++; $display("FAIL mode_inc_collide2: got %0d/%h want 3/%h", mode, disp_all, exp_disp()); end
        modes(3);
        modes(1); incs(59);
        modes(3);
        ticks(59);
        total++; if (disp_all !== 24'h072959) begin bad++; $display("FAIL pre_collide: got %h want 072959", disp_all); end
        step(1, 0, 0, 1);
        total++; if (ringing !== 1'b1) begin bad++; $display("FAIL stop_vs_trigger: got %b want 1", ringing); end
    endtask

    task automatic test_reset_midring();
        modes(4);
        total++; if (mode !== 3'd4 || ringing !== 1'b1) begin bad++; $display("FAIL pre_reset: got %0d/%b want 4/1", mode, ringing); end
        #2 rst_n = 0;
        #1;
        model_reset();
        total++; if (mode !== 3'd0 || disp_all !== 24'h000000 || ringing !== 1'b0) begin
            bad++; $display("FAIL async_reset: got %0d/%h/%b want 0/000000/0", mode, disp_all, ringing);
        end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_random();
        alarm_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
            total++;
            if (mode !== 3'(m_mode) || disp_all !== exp_disp() || ringing !== m_ring) begin
                bad++;
                $display("FAIL random[%0d]: got %0d/%h/%b want %0d/%h/%b",
                         i, mode, disp_all, ringing, m_mode, exp_disp(), m_ring);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_set_time();
        test_wrap();
        test_alarm_timeout();
        test_stop_collision();
        test_reset_midring();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL have the ports listed below. Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick_1hz  input  1  one-clk-wide pulse, once per second.
- mode_btn  input  1  debounced one-clk pulse; advances the mode.
- inc_btn  input  1  debounced one-clk pulse; increments the selected field.
- stop_btn  input  1  debounced one-clk pulse; silences the alarm.
- alarm_en  input  1  level; 1 arms the alarm.
- mode  output  3  current state encoding.
- disp_h1, disp_h0, disp_m1, disp_m0, disp_s1, disp_s0  output  4 each  BCD display digits.
- ringing  output  1  alarm active.

Function
REQ-002 The states SHALL be RUN=0, SET_T_HR=1, SET_T_MIN=2, SET_A_HR=3, SET_A_MIN=4; mode_btn SHALL step 0->1->2->3->4->0, one step per pulse.
REQ-003 The time seconds and minutes SHALL each count 00..59 in BCD. Hours SHALL count 00..23 in BCD. The low digit SHALL wrap 9->0 with a carry into the high digit.
REQ-004 In RUN, SET_A_HR and SET_A_MIN, each tick_1hz SHALL advance seconds. A seconds carry at 59 SHALL advance minutes, and a minutes carry at 59 SHALL advance hours. 23:59:59 + tick SHALL give 00:00:00 in the same edge.
REQ-005 Entering SET_T_HR SHALL clear seconds to 00. In SET_T_HR and SET_T_MIN, the time SHALL be frozen and tick_1hz ignored.
REQ-006 inc_btn behaviour by state:
- SET_T_HR: increment the time hour, mod 24.
- SET_T_MIN: increment the time minute, mod 60.
- SET_A_HR / SET_A_MIN: increment the alarm hour or alarm minute in the same way.
- Field increments SHALL never carry into another field.
- In RUN, inc_btn SHALL be ignored.
REQ-007 If mode_btn and inc_btn arrive in the same cycle, the mode change SHALL win and inc_btn SHALL be dropped.
REQ-008 Display source by state:
- RUN, SET_T_*: the disp_* digits SHALL show the time.
- SET_A_*: the disp_* digits SHALL show the alarm hh:mm, with disp_s1/disp_s0 = 0.
- Display outputs SHALL be registered or derived from registers, with no combinational path from the buttons.
REQ-009 Alarm trigger: ringing SHALL set on the edge where a tick makes the time equal alarm_hh:alarm_mm:00, provided alarm_en=1 and the state is not SET_T_*.
REQ-010 While ringing, a 6-bit ring counter SHALL count ticks. ringing SHALL clear when either of these occurs:
- stop_btn is pulsed, or
- 60 ticks have elapsed after the trigger.
Whichever occurs first SHALL win.
REQ-011 Other ring-clear conditions:
- alarm_en dropping to 0 SHALL clear ringing on the next edge.
- stop_btn while not ringing SHALL have no effect.
- A re-trigger while already ringing SHALL NOT restart the ring counter.
REQ-012 If stop_btn and a trigger occur in the same cycle, the trigger SHALL win and ringing SHALL be 1.

Reset
REQ-013 rst_n=0 SHALL immediately force:
- time to 00:00:00 and alarm to 00:00;
- mode to RUN;
- ringing to 0 and the ring counter to 0.
REQ-014 Reset asserted mid-ring or mid-set SHALL abandon that operation; no state SHALL survive reset.

Structure
REQ-015 A shared package/header SHALL hold:
- the state encodings;
- the constants HOUR_MAX=23, MIN_SEC_MAX=59 and RING_TICKS=60.
REQ-016 One sub-module, bcd_mod_cnt, SHALL be used:
- parameterised on its maximum value;
- inputs: clk, rst_n, en, clr;
- outputs: 2-digit BCD and carry.
- It SHALL be instantiated for seconds, minutes and hours of the time and of the alarm.

Verification
REQ-017 Wrap: preload 23:59:58, apply 2 ticks -> 23:59:59, then 00:00:00, with no intermediate value visible.
REQ-018 Set time: starting from RUN with seconds=37, apply the following:
- mode once: seconds read 00.
- 25 inc pulses: hour +25 mod 24.
- mode once, then 61 inc pulses: minute +61 mod 60.
- Ticks during these states: time unchanged.
REQ-019 Alarm timeout: set the alarm to 07:30 with alarm_en=1, and run to 07:29:59 -> the next tick raises ringing. After 60 further ticks, ringing drops.
REQ-020 Stop and collisions:
- At 07:30:10, stop_btn clears ringing on the next edge.
- mode_btn and inc_btn in the same cycle advance the mode only.
- stop_btn together with the trigger tick leaves ringing=1.
REQ-021 Reset: assert rst_n=0 asynchronously mid-ring while in SET_A_MIN -> all outputs return to zero/RUN without waiting for a clk edge.
